mandel_pixel_scheduler: RTL and testbench

MANDEL_PIXEL_SCHEDULER -- requirements
Module: mandel_pixel_scheduler

---
 rtl/mandel_pixel_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_scheduler.sv
// Frame pixel scheduler for a bank of mandelbrot_iterate lanes: walks the screen in raster
// order, hands each pixel's c to a free lane, and drains finished counts through a
// round-robin write port.
module mandel_pixel_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [26:0]          cr_start,
    input  logic signed [26:0]          ci_start,
    input  logic signed [26:0]          dcr,
    input  logic signed [26:0]          dci,
    input  logic [15:0]                 max_iterations,
    output logic [NUM_LANES-1:0]        lane_reset,
    output logic [27*NUM_LANES-1:0]     lane_cr,
    output logic [27*NUM_LANES-1:0]     lane_ci,
    input  logic [16*NUM_LANES-1:0]     lane_iterations,
    input  logic [NUM_LANES-1:0]        lane_flag,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [18:0]                 wr_addr,
    output logic [15:0]                 wr_data,
    output logic                        busy,
    output logic                        done
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic                    busy_q, busy_d, done_q, done_d, all_disp_q, all_disp_d;
    logic signed [26:0]      cr0_q, cr0_d, dcr_q, dcr_d, dci_q, dci_d;
    logic signed [26:0]      cur_cr_q, cur_cr_d, cur_ci_q, cur_ci_d;
    logic [15:0]             max_q, max_d, x_q, x_d, y_q, y_d;
    logic [18:0]             pix_addr_q, pix_addr_d;
    logic [1:0]              state_q [NUM_LANES];
    logic [1:0]              state_d [NUM_LANES];
    logic [18:0]             lane_addr_q [NUM_LANES];
    logic [18:0]             lane_addr_d [NUM_LANES];
    logic [15:0]             lane_res_q [NUM_LANES];
    logic [15:0]             lane_res_d [NUM_LANES];
    logic [27*NUM_LANES-1:0] lane_cr_q, lane_cr_d, lane_ci_q, lane_ci_d;
    logic [NUM_LANES-1:0]    lane_reset_q, lane_reset_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [18:0]             wr_addr_q, wr_addr_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic [LW-1:0]           gnt_q, gnt_d, rr_q, rr_d;

    logic handshake_s, dispatch_s, disp_found_s, arb_found_s, others_idle_s;
    int   disp_idx_s, arb_idx_s, arb_best_s, dist_s;

    // Next-state logic for frame walk, lane FSMs and write arbiter.
    always_comb begin
        busy_d = busy_q;  done_d = 1'b0;  all_disp_d = all_disp_q;
        cr0_d = cr0_q;  dcr_d = dcr_q;  dci_d = dci_q;  max_d = max_q;
        cur_cr_d = cur_cr_q;  cur_ci_d = cur_ci_q;
        x_d = x_q;  y_d = y_q;  pix_addr_d = pix_addr_q;
        state_d = state_q;  lane_addr_d = lane_addr_q;  lane_res_d = lane_res_q;
        lane_cr_d = lane_cr_q;  lane_ci_d = lane_ci_q;
        wr_valid_d = wr_valid_q;  wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
        gnt_d = gnt_q;  rr_d = rr_q;
        disp_found_s = 1'b0;  disp_idx_s = 0;
        arb_found_s = 1'b0;  arb_idx_s = 0;  arb_best_s = NUM_LANES;  dist_s = 0;
        others_idle_s = 1'b1;
        handshake_s = wr_valid_q & wr_ready;

        for (int i = 0; i < NUM_LANES; i++) begin
            if (!disp_found_s && state_q[i] == ST_IDLE) begin
                disp_found_s = 1'b1;
                disp_idx_s   = i;
            end else begin
                disp_found_s = disp_found_s;
            end
            others_idle_s = others_idle_s &
                            ((state_q[i] == ST_IDLE) || (int'(gnt_q) == i));
        end
        dispatch_s = busy_q & ~all_disp_q & disp_found_s;

        for (int i = 0; i < NUM_LANES; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (dispatch_s && disp_idx_s == i) begin
                        state_d[i]           = ST_LOAD;
                        lane_cr_d[i*27 +: 27] = cur_cr_q;
                        lane_ci_d[i*27 +: 27] = cur_ci_q;
                        lane_addr_d[i]       = pix_addr_q;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_LOAD: state_d[i] = ST_RUN;
                ST_RUN: begin
                    if (lane_iterations[i*16 +: 16] >= max_q || !lane_flag[i]) begin
                        state_d[i]    = ST_DONE;
                        lane_res_d[i] = lane_iterations[i*16 +: 16];
                    end else begin
                        state_d[i] = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (handshake_s && int'(gnt_q) == i) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_DONE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end

        // Round-robin: smallest rotated distance from rr_q among DONE lanes wins.
        for (int i = 0; i < NUM_LANES; i++) begin
            dist_s = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + NUM_LANES - int'(rr_q));
            if (state_q[i] == ST_DONE && dist_s < arb_best_s) begin
                arb_found_s = 1'b1;
                arb_best_s  = dist_s;
                arb_idx_s   = i;
            end else begin
                arb_found_s = arb_found_s;
            end
        end

        if (!wr_valid_q) begin
            if (arb_found_s) begin
                wr_valid_d = 1'b1;
                gnt_d      = LW'(arb_idx_s);
                rr_d       = (arb_idx_s == NUM_LANES - 1) ? '0 : LW'(arb_idx_s + 1);
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (i == arb_idx_s) begin
                        wr_addr_d = lane_addr_q[i];
                        wr_data_d = lane_res_q[i];
                    end else begin
                        wr_addr_d = wr_addr_d;
                    end
                end
            end else begin
                wr_valid_d = 1'b0;
            end
        end else if (handshake_s) begin
            wr_valid_d = 1'b0;
        end else begin
            wr_valid_d = 1'b1;
        end

        if (start && !busy_q) begin
            busy_d = 1'b1;  all_disp_d = 1'b0;
            cr0_d = cr_start;  dcr_d = dcr;  dci_d = dci;  max_d = max_iterations;
            cur_cr_d = cr_start;  cur_ci_d = ci_start;
            x_d = 16'd0;  y_d = 16'd0;  pix_addr_d = 19'd0;
        end else if (dispatch_s) begin
            pix_addr_d = pix_addr_q + 19'd1;
            if (x_q != 16'(SCREEN_W - 1)) begin
                x_d      = x_q + 16'd1;
                cur_cr_d = cur_cr_q + dcr_q;
            end else begin
                x_d      = 16'd0;
                y_d      = y_q + 16'd1;
                cur_cr_d = cr0_q;
                cur_ci_d = cur_ci_q + dci_q;
                all_disp_d = (y_q == 16'(SCREEN_H - 1));
            end
        end else begin
            busy_d = busy_q;
        end

        // The final handshake leaves every lane idle once it retires.
        if (busy_q && handshake_s && all_disp_q && others_idle_s) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end else begin
            done_d = 1'b0;
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            lane_reset_d[i] = (state_d[i] == ST_IDLE) || (state_d[i] == ST_LOAD);
        end
    end

    // State registers with synchronous reset that drops any in-flight frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;  done_q <= 1'b0;  all_disp_q <= 1'b0;
            cr0_q <= 27'sd0;  dcr_q <= 27'sd0;  dci_q <= 27'sd0;  max_q <= 16'd0;
            cur_cr_q <= 27'sd0;  cur_ci_q <= 27'sd0;
            x_q <= 16'd0;  y_q <= 16'd0;  pix_addr_q <= 19'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i]     <= ST_IDLE;
                lane_addr_q[i] <= 19'd0;
                lane_res_q[i]  <= 16'd0;
            end
            lane_cr_q <= '0;  lane_ci_q <= '0;  lane_reset_q <= '1;
            wr_valid_q <= 1'b0;  wr_addr_q <= 19'd0;  wr_data_q <= 16'd0;
            gnt_q <= '0;  rr_q <= '0;
        end else begin
            busy_q <= busy_d;  done_q <= done_d;  all_disp_q <= all_disp_d;
            cr0_q <= cr0_d;  dcr_q <= dcr_d;  dci_q <= dci_d;  max_q <= max_d;
            cur_cr_q <= cur_cr_d;  cur_ci_q <= cur_ci_d;
            x_q <= x_d;  y_q <= y_d;  pix_addr_q <= pix_addr_d;
            state_q <= state_d;  lane_addr_q <= lane_addr_d;  lane_res_q <= lane_res_d;
            lane_cr_q <= lane_cr_d;  lane_ci_q <= lane_ci_d;  lane_reset_q <= lane_reset_d;
            wr_valid_q <= wr_valid_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
            gnt_q <= gnt_d;  rr_q <= rr_d;
        end
    end

    assign lane_reset = lane_reset_q;
    assign lane_cr    = lane_cr_q;
    assign lane_ci    = lane_ci_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler on a 4x2 screen with two behavioural iterator lanes;
// a scoreboard of per-pixel expected counts is matched against every write.
module tb_mandel_pixel_scheduler;
    localparam int NL = 2;
    localparam int W  = 4;
    localparam int H  = 2;

    logic                clk = 1'b0;
    logic                reset, start, wr_ready;
    logic signed [26:0]  cr_start, ci_start, dcr, dci;
    logic [15:0]         max_iterations;
    logic [NL-1:0]       lane_reset, lane_flag;
    logic [27*NL-1:0]    lane_cr, lane_ci;
    logic [16*NL-1:0]    lane_iterations;
    logic                wr_valid, busy, done;
    logic [18:0]         wr_addr;
    logic [15:0]         wr_data;

    typedef struct { logic [18:0] addr; logic [15:0] data; } sb_entry_t;
    sb_entry_t sb[$];
    int n_vec = 0, n_miss = 0, wr_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    mandel_pixel_scheduler #(.NUM_LANES(NL), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cr_start(cr_start), .ci_start(ci_start), .dcr(dcr), .dci(dci),
        .max_iterations(max_iterations),
        .lane_reset(lane_reset), .lane_cr(lane_cr), .lane_ci(lane_ci),
        .lane_iterations(lane_iterations), .lane_flag(lane_flag),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // z^2 + c in 4.23 fixed point, wrapping to 27 bits.
    function automatic logic signed [26:0] step_r(logic signed [26:0] zr, logic signed [26:0] zi,
                                                   logic signed [26:0] c);
        longint p;
        p = (longint'(zr) * longint'(zr) - longint'(zi) * longint'(zi)) >>> 23;
        return 27'(p + longint'(c));
    endfunction

    function automatic logic signed [26:0] step_i(logic signed [26:0] zr, logic signed [26:0] zi,
                                                   logic signed [26:0] c);
        longint p;
        p = (longint'(2) * longint'(zr) * longint'(zi)) >>> 23;
        return 27'(p + longint'(c));
    endfunction

    function automatic logic in_disk(logic signed [26:0] zr, logic signed [26:0] zi);
        longint m;
        m = longint'(zr) * longint'(zr) + longint'(zi) * longint'(zi);
        return m <= (longint'(1) <<< 48);
    endfunction

    function automatic logic [15:0] ref_count(logic signed [26:0] cr, logic signed [26:0] ci,
                                              logic [15:0] mx);
        logic signed [26:0] zr, zi, nr;
        zr = 27'sd0;  zi = 27'sd0;
        for (int k = 0; k < 1000; k++) begin
            if (k >= int'(mx) || !in_disk(zr, zi)) return 16'(k);
            nr = step_r(zr, zi, cr);
            zi = step_i(zr, zi, ci);
            zr = nr;
        end
        return 16'hFFFF;
    endfunction

    // Behavioural iterator lanes: cleared while lane_reset, one z-step per cycle until escape.
    logic signed [26:0] zr_l [NL];
    logic signed [26:0] zi_l [NL];
    logic [15:0]        it_l [NL];
    logic               fl_l [NL];
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (lane_reset[i]) begin
                zr_l[i] <= 27'sd0;  zi_l[i] <= 27'sd0;  it_l[i] <= 16'd0;  fl_l[i] <= 1'b1;
            end else if (fl_l[i]) begin
                zr_l[i] <= step_r(zr_l[i], zi_l[i], lane_cr[i*27 +: 27]);
                zi_l[i] <= step_i(zr_l[i], zi_l[i], lane_ci[i*27 +: 27]);
                it_l[i] <= it_l[i] + 16'd1;
                fl_l[i] <= in_disk(step_r(zr_l[i], zi_l[i], lane_cr[i*27 +: 27]),
                                   step_i(zr_l[i], zi_l[i], lane_ci[i*27 +: 27]));
            end
        end
    end
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            lane_iterations[i*16 +: 16] = it_l[i];
            lane_flag[i]                = fl_l[i];
        end
    end

    // Write/done monitor against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_valid && wr_ready) begin
                int idx;
                idx = -1;
                for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].addr == wr_addr) idx = k;
                if (idx >= 0) begin
                    check_val("wr_data", 64'(wr_data), 64'(sb[idx].data));
                    sb.delete(idx);
                end else begin
                    check_val("wr_addr_unexpected", 64'(wr_addr), 64'hFFFF_FFFF);
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                check_val("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic build_sb(input logic signed [26:0] cr, input logic signed [26:0] ci,
                            input logic signed [26:0] dr, input logic signed [26:0] di,
                            input logic [15:0] mx, input bit use_ref, input logic [15:0] cval);
        sb_entry_t e;
        sb.delete();
        for (int a = 0; a < W * H; a++) begin
            e.addr = 19'(a);
            e.data = use_ref ? ref_count(27'(cr + dr * (a % W)), 27'(ci + di * (a / W)), mx) : cval;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic signed [26:0] cr, input logic signed [26:0] ci,
                               input logic signed [26:0] dr, input logic signed [26:0] di,
                               input logic [15:0] mx);
        @(negedge clk);
        cr_start = cr;  ci_start = ci;  dcr = dr;  dci = di;  max_iterations = mx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic signed [26:0] cr, input logic signed [26:0] ci,
                             input logic signed [26:0] dr, input logic signed [26:0] di,
                             input logic [15:0] mx, input bit use_ref, input logic [15:0] cval,
                             input bit stall, input bit repulse);
        logic [18:0] sa;
        logic [15:0] sd;
        build_sb(cr, ci, dr, di, mx, use_ref, cval);
        wr_cnt = 0;  done_cnt = 0;
        pulse_start(cr, ci, dr, di, mx);
        check_val("busy_after_start", 64'(busy), 64'd1);
        if (repulse) begin
            repeat (3) @(negedge clk);
            pulse_start(27'sd1234567, 27'sd7654, 27'sd99, 27'sd5, 16'd3);
        end
        if (stall) begin
            repeat (4) @(negedge clk);
            wr_ready = 1'b0;
            for (int c = 0; c < 100 && !wr_valid; c++) @(negedge clk);
            check_val("stall_valid_seen", 64'(wr_valid), 64'd1);
            sa = wr_addr;  sd = wr_data;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                check_val("stall_valid", 64'(wr_valid), 64'd1);
                check_val("stall_addr", 64'(wr_addr), 64'(sa));
                check_val("stall_data", 64'(wr_data), 64'(sd));
            end
            wr_ready = 1'b1;
        end
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_val("done_count", 64'(done_cnt), 64'd1);
        check_val("write_count", 64'(wr_cnt), 64'(W * H));
        check_val("sb_left", 64'(sb.size()), 64'd0);
        check_val("busy_end", 64'(busy), 64'd0);
        check_val("lane_reset_end", 64'(lane_reset), 64'(2'b11));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
        check_val({tag, "_lane_reset"}, 64'(lane_reset), 64'(2'b11));
        check_val({tag, "_lane_cr"}, 64'(lane_cr), 64'd0);
        check_val({tag, "_lane_ci"}, 64'(lane_ci), 64'd0);
        check_val({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check_val({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    initial begin
        reset = 1'b1;  start = 1'b0;  wr_ready = 1'b1;
        cr_start = 27'sd0;  ci_start = 27'sd0;  dcr = 27'sd0;  dci = 27'sd0;
        max_iterations = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        // max=0: every pixel retires with count 0
        run_frame(27'sd0, 27'sd0, 27'sd0, 27'sd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        // c=0 never escapes: count saturates at max
        run_frame(27'sd0, 27'sd0, 27'sd0, 27'sd0, 16'd10, 1'b0, 16'd10, 1'b0, 1'b0);
        // c=2.0 escapes after two steps
        run_frame(27'sh1000000, 27'sd0, 27'sd0, 27'sd0, 16'd50, 1'b0, 16'd2, 1'b0, 1'b0);
        // real window, out-of-order completion
        run_frame(-27'sd16777216, -27'sd8388608, 27'sd6291456, 27'sd8388608, 16'd20,
                  1'b1, 16'd0, 1'b0, 1'b0);
        // write back-pressure mid-frame
        run_frame(27'sd0, 27'sd0, 27'sd0, 27'sd0, 16'd10, 1'b0, 16'd10, 1'b1, 1'b0);
        // start re-pulsed while busy is ignored
        run_frame(-27'sd16777216, -27'sd8388608, 27'sd6291456, 27'sd8388608, 16'd20,
                  1'b1, 16'd0, 1'b0, 1'b1);

        // reset mid-frame, then a clean frame
        build_sb(27'sd0, 27'sd0, 27'sd0, 27'sd0, 16'd10, 1'b0, 16'd10);
        pulse_start(27'sd0, 27'sd0, 27'sd0, 27'sd0, 16'd10);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        sb.delete();
        run_frame(27'sh0800000, 27'sd0, -27'sd2097152, 27'sd4194304, 16'd15,
                  1'b1, 16'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
